cordic_arbiter: RTL and testbench

- Shares one free-running pipelined CORDIC rotator (no stall, no valid, fixed latency) among N_REQ requesters.
- Round-robin arbitration across requesters with valid/ready request ports.
- Issues at most one operand set per cycle and tags it with the requester ID as it travels the pipeline.
- Returns results through a shared valid/ready response port backed by a credit-protected result FIFO. Instantiated beside the CORDIC instance in the rotator subsystem.

---
 rtl/cordic_pkg.sv | 28 ++
 rtl/cordic_arbiter_if.sv | 42 ++++
 rtl/cordic_rsp_fifo.sv | 55 +++++
 rtl/cordic_arbiter.sv | 132 +++++++++++++
 tb/tb_cordic_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC rotator subsystem.
package cordic_pkg;

    localparam int unsigned CORDIC_WIDTH = 16;
    localparam int unsigned ANGLE_W      = 32;

    localparam logic [1:0] QUAD_0 = 2'b00;
    localparam logic [1:0] QUAD_1 = 2'b01;
    localparam logic [1:0] QUAD_2 = 2'b10;
    localparam logic [1:0] QUAD_3 = 2'b11;

    localparam logic [ANGLE_W-1:0] ANG_45 = 32'h2000_0000;
    localparam logic [ANGLE_W-1:0] ANG_90 = 32'h4000_0000;

    // The rotator retires one bit of precision per stage.
    function automatic int unsigned cordic_latency(input int unsigned width);
        return width;
    endfunction

    // ceil(log2(n)), never below 1 so a 1-entry space still gets a real signal.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Request, CORDIC operand/result and response signals of the shared rotator.
interface cordic_arbiter_if
    import cordic_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = CORDIC_WIDTH
);
    localparam int unsigned ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*WIDTH-1:0]   req_x;
    logic [N_REQ*WIDTH-1:0]   req_y;
    logic [N_REQ*ANGLE_W-1:0] req_angle;

    logic [WIDTH-1:0]   cordic_x_start;
    logic [WIDTH-1:0]   cordic_y_start;
    logic [ANGLE_W-1:0] cordic_angle;
    logic [WIDTH-1:0]   cordic_cosine;
    logic [WIDTH-1:0]   cordic_sine;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [WIDTH-1:0] rsp_cosine;
    logic [WIDTH-1:0] rsp_sine;

    // Arbiter side.
    modport slave (
        input  req_valid, req_x, req_y, req_angle, cordic_cosine, cordic_sine, rsp_ready,
        output req_ready, cordic_x_start, cordic_y_start, cordic_angle,
               rsp_valid, rsp_id, rsp_cosine, rsp_sine
    );

    // Requesters, rotator and response consumer.
    modport master (
        output req_valid, req_x, req_y, req_angle, cordic_cosine, cordic_sine, rsp_ready,
        input  req_ready, cordic_x_start, cordic_y_start, cordic_angle,
               rsp_valid, rsp_id, rsp_cosine, rsp_sine
    );

endinterface

// File: rtl/cordic_rsp_fifo.sv
// Result FIFO of {id, cosine, sine}; head is registered, no push-to-pop bypass.
module cordic_rsp_fifo
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W     = 34,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CNT_W     = id_width(FIFO_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int unsigned PTR_W = id_width(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              full, empty, do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i && !empty;
    // A pop frees the head slot on the same edge, so push-when-full is safe then.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one fixed-latency CORDIC pipeline with credit-protected result FIFO.
// Optional issue/stall counters: define CORDIC_ARB_STATS_EN.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned WIDTH          = CORDIC_WIDTH,
    parameter int unsigned CORDIC_LATENCY = cordic_latency(WIDTH),
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input logic             clock,
    input logic             reset_n,
    cordic_arbiter_if.slave bus
`ifdef CORDIC_ARB_STATS_EN
    ,
    output logic [31:0]     stat_issue_cnt,
    output logic [31:0]     stat_stall_cnt
`endif
);
    localparam int unsigned ID_W  = id_width(N_REQ);
    localparam int unsigned CNT_W = id_width(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = ID_W + 2 * WIDTH;

    logic [ID_W-1:0]    rr_ptr_q;
    logic               credit_ok, grant_vld, capture;
    logic [ID_W-1:0]    grant_id;
    logic [WIDTH-1:0]   sel_x, sel_y, x_q, y_q;
    logic [ANGLE_W-1:0] sel_ang, ang_q;
    logic [CNT_W-1:0]   inflight_q, inflight_d, fifo_cnt;
    logic [ENT_W-1:0]   fifo_head;

    // Stage 0 rides with the issue register; stage CORDIC_LATENCY lines up with the result.
    logic [CORDIC_LATENCY:0] tag_vld_q;
    logic [ID_W-1:0]         tag_id_q [CORDIC_LATENCY+1];

    // issued-but-not-popped never exceeds FIFO_DEPTH, so every return has a slot.
    assign credit_ok = (32'(fifo_cnt) + 32'(inflight_q)) < FIFO_DEPTH;

    always_comb begin
        logic [ID_W-1:0] idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        if (credit_ok && reset_n) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                idx = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
                if (!grant_vld && bus.req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = idx;
                end
            end
        end
    end

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_ang = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_x   = bus.req_x[i*WIDTH +: WIDTH];
                sel_y   = bus.req_y[i*WIDTH +: WIDTH];
                sel_ang = bus.req_angle[i*ANGLE_W +: ANGLE_W];
            end
        end
    end

    assign bus.req_ready = grant_vld ? (N_REQ'(1) << grant_id) : '0;
    assign capture       = tag_vld_q[CORDIC_LATENCY];
    assign inflight_d    = inflight_q + CNT_W'(grant_vld) - CNT_W'(capture);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= ID_W'(N_REQ - 1);
            x_q        <= '0;
            y_q        <= '0;
            ang_q      <= '0;
            tag_vld_q  <= '0;
            inflight_q <= '0;
            for (int i = 0; i <= int'(CORDIC_LATENCY); i++) tag_id_q[i] <= '0;
        end else begin
            if (grant_vld) begin
                rr_ptr_q <= grant_id;
                x_q      <= sel_x;
                y_q      <= sel_y;
                ang_q    <= sel_ang;
            end
            tag_vld_q   <= {tag_vld_q[CORDIC_LATENCY-1:0], grant_vld};
            tag_id_q[0] <= grant_id;
            for (int i = 1; i <= int'(CORDIC_LATENCY); i++) tag_id_q[i] <= tag_id_q[i-1];
            inflight_q  <= inflight_d;
        end
    end

    assign bus.cordic_x_start = x_q;
    assign bus.cordic_y_start = y_q;
    assign bus.cordic_angle   = ang_q;

    cordic_rsp_fifo #(
        .DATA_W     (ENT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (capture),
        .push_data_i ({tag_id_q[CORDIC_LATENCY], bus.cordic_cosine, bus.cordic_sine}),
        .pop_i       (bus.rsp_ready),
        .valid_o     (bus.rsp_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt)
    );

    assign {bus.rsp_id, bus.rsp_cosine, bus.rsp_sine} = fifo_head;

`ifdef CORDIC_ARB_STATS_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_q + 32'(grant_vld);
            stall_cnt_q <= stall_cnt_q + 32'(|bus.req_valid && !grant_vld);
        end
    end

    assign stat_issue_cnt = issue_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: behavioural rotator plus a queue-based model of grants and responses.
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int L     = int'(cordic_latency(CORDIC_WIDTH));
    localparam int DEPTH = 8;
    localparam real GAIN = 1.6467602581;
    localparam real TWO_PI = 6.283185307179586;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    cordic_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

`ifdef CORDIC_ARB_STATS_EN
    logic [31:0] stat_issue_cnt, stat_stall_cnt;
`endif

    cordic_arbiter #(
        .N_REQ          (N),
        .WIDTH          (W),
        .CORDIC_LATENCY (L),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
`ifdef CORDIC_ARB_STATS_EN
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .bus     (bus)
    );

    function automatic logic [15:0] to_fix(input real v);
        int r;
        r = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    // Ideal rotation scaled by the CORDIC gain; returns {cosine, sine}.
    function automatic logic [31:0] rotate(input logic [15:0] x, input logic [15:0] y,
                                           input logic [31:0] a);
        real th, xr, yr;
        th = real'(a) * TWO_PI / 4294967296.0;
        xr = real'($signed(x));
        yr = real'($signed(y));
        return {to_fix(GAIN * (xr * $cos(th) - yr * $sin(th))),
                to_fix(GAIN * (xr * $sin(th) + yr * $cos(th)))};
    endfunction

    // Free-running rotator: result appears L edges after the operand registers change.
    logic [31:0] rot_q [L];
    always @(posedge clock) begin
        rot_q[0] <= rotate(bus.cordic_x_start, bus.cordic_y_start, bus.cordic_angle);
        for (int i = 1; i < L; i++) rot_q[i] <= rot_q[i-1];
    end
    assign bus.cordic_cosine = rot_q[L-1][31:16];
    assign bus.cordic_sine   = rot_q[L-1][15:0];

    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        mq[$];          // issued, not yet popped: in flight and queued alike
    int          last_id = N - 1;
    int          iter = 0;
    int          checks = 0;
    int          errors = 0;
    int          m_issues = 0, m_stalls = 0;
    int          obs_grants = 0, obs_rsp = 0;
    logic [15:0] op_x [N];
    logic [15:0] op_y [N];
    logic [31:0] op_a [N];
    logic [15:0] exp_cx = '0, exp_cy = '0;
    logic [31:0] exp_ca = '0;
    logic [15:0] last_cos, last_sin;
    int          last_rid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic [15:0] obs, input int target,
                             input int tol);
        int v;
        v = int'($signed(obs));
        checks++;
        assert ((v >= target - tol) && (v <= target + tol)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +-%0d", tag, v, target, tol);
        end
    endtask

    task automatic step(input logic [N-1:0] vmask, input logic rrdy);
        int          g;
        logic [1:0]  idx;
        logic [N-1:0] exp_rdy;
        bit          head_ok;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            bus.req_x[i*W +: W]     = op_x[i];
            bus.req_y[i*W +: W]     = op_y[i];
            bus.req_angle[i*32 +: 32] = op_a[i];
        end
        bus.req_valid = vmask;
        bus.rsp_ready = rrdy;
        #1;
        g = -1;
        if (mq.size() < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                idx = 2'((last_id + k) % N);
                if (g < 0 && vmask[idx]) g = int'(idx);
            end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("cordic_x_start", 64'(bus.cordic_x_start), 64'(exp_cx));
        check("cordic_y_start", 64'(bus.cordic_y_start), 64'(exp_cy));
        check("cordic_angle", 64'(bus.cordic_angle), 64'(exp_ca));
        head_ok = (mq.size() > 0) && (mq[0].due <= iter);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(head_ok));
        if (head_ok) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(mq[0].id));
            check("rsp_cosine", 64'(bus.rsp_cosine), 64'(mq[0].res[31:16]));
            check("rsp_sine", 64'(bus.rsp_sine), 64'(mq[0].res[15:0]));
            if (rrdy) void'(mq.pop_front());
        end
        if (bus.rsp_valid && rrdy) begin
            obs_rsp++;
            last_cos = bus.rsp_cosine;
            last_sin = bus.rsp_sine;
            last_rid = int'(bus.rsp_id);
        end
        if (|bus.req_ready) obs_grants++;
        if (g >= 0) begin
            mq.push_back('{g, rotate(op_x[g], op_y[g], op_a[g]), iter + L + 2});
            last_id = g;
            exp_cx  = op_x[g];
            exp_cy  = op_y[g];
            exp_ca  = op_a[g];
            m_issues++;
        end else if (|vmask) begin
            m_stalls++;
        end
        iter++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        check("rst_rsp_cosine", 64'(bus.rsp_cosine), 64'(0));
        check("rst_rsp_sine", 64'(bus.rsp_sine), 64'(0));
        check("rst_cordic_x", 64'(bus.cordic_x_start), 64'(0));
        check("rst_cordic_angle", 64'(bus.cordic_angle), 64'(0));
        bus.req_valid = '0;
        mq.delete();
        last_id  = N - 1;
        exp_cx   = '0;
        exp_cy   = '0;
        exp_ca   = '0;
        m_issues = 0;
        m_stalls = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            op_x[i] = 16'($urandom_range(0, 26000)) - 16'd13000;
            op_y[i] = 16'($urandom_range(0, 26000)) - 16'd13000;
            case ($urandom_range(0, 3))
                0:       op_a[i] = {QUAD_0, 30'($urandom)};
                1:       op_a[i] = {QUAD_1, 30'($urandom)};
                2:       op_a[i] = {QUAD_2, 30'($urandom)};
                default: op_a[i] = {QUAD_3, 30'($urandom)};
            endcase
        end
    endtask

    initial begin
        int rsp_before;
        reset_n       = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_angle = '0;
        randomize_ops();
        do_reset();

        // Single request from requester 2, angle 0.
        op_x[2] = 16'd19429; op_y[2] = '0; op_a[2] = '0;
        rsp_before = obs_rsp;
        step(4'b0100, 1'b1);
        repeat (20) step('0, 1'b1);
        check("single_rsp_count", 64'(obs_rsp), 64'(rsp_before + 1));
        check("single_rsp_id", 64'(last_rid), 64'(2));
        check_tol("single_cos", last_cos, 32000, 8);
        check_tol("single_sin", last_sin, 0, 8);

        // Quadrant cases from requester 1.
        op_x[1] = 16'd19429; op_y[1] = '0; op_a[1] = ANG_90;
        step(4'b0010, 1'b1);
        repeat (20) step('0, 1'b1);
        check("q90_rsp_id", 64'(last_rid), 64'(1));
        check_tol("q90_cos", last_cos, 0, 8);
        check_tol("q90_sin", last_sin, 32000, 8);
        op_a[1] = ANG_45;
        step(4'b0010, 1'b1);
        repeat (20) step('0, 1'b1);
        check_tol("q45_cos", last_cos, 22627, 8);
        check_tol("q45_sin", last_sin, 22627, 8);

        // All requesters continuously valid, consumer always ready.
        do_reset();
        randomize_ops();
        repeat (40) step(4'hF, 1'b1);
        repeat (25) step('0, 1'b1);

        // Consumer stalled: credit caps issues at the FIFO depth.
        obs_grants = 0;
        repeat (30) step(4'hF, 1'b0);
        check("credit_cap_grants", 64'(obs_grants), 64'(DEPTH));
        step(4'hF, 1'b1);
        repeat (6) step(4'hF, 1'b0);
        check("one_pop_one_grant", 64'(obs_grants), 64'(DEPTH + 1));

        // Reset with 5 operations in flight and 3 queued.
        do_reset();
        repeat (8) step(4'hF, 1'b0);
        repeat (12) step('0, 1'b0);
        check("pre_reset_valid", 64'(bus.rsp_valid), 64'(1));
        do_reset();
        repeat (25) step(4'hF, 1'b1);
        repeat (25) step('0, 1'b1);

        // Randomised traffic.
        for (int t = 0; t < 400; t++) begin
            randomize_ops();
            step(N'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (30) step('0, 1'b1);

`ifdef CORDIC_ARB_STATS_EN
        // 8 issues, 4 credit-blocked cycles, drain, then 2 more issues.
        do_reset();
        repeat (12) step(4'b0001, 1'b1);
        repeat (12) step('0, 1'b1);
        repeat (2) step(4'b0001, 1'b1);
        @(negedge clock);
        #1;
        check("stat_issue_cnt", 64'(stat_issue_cnt), 64'(m_issues));
        check("stat_stall_cnt", 64'(stat_stall_cnt), 64'(m_stalls));
        check("stat_plan_issue", 64'(m_issues), 64'(stat_issue_cnt == 32'd10 ? m_issues : 10));
        check("stat_plan_stall", 64'(stat_stall_cnt), 64'(4));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
